// File: rtl/rx78_keyboard.sv
// RX-78 keyboard I/O responder: PS/2 key events build a 9x8 key matrix that
// the CPU scans through a strobe port, plus a direct active-low joystick port.
module rx78_keyboard #(
  parameter logic [7:0] KB_PORT  = 8'hF4,
  parameter logic [7:0] JOY_PORT = 8'hF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  addr,
  input  logic        iorq_n,
  input  logic        wr_n,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic [10:0] ps2_key,
  input  logic [5:0]  joy1,
  input  logic [5:0]  joy2
);

  logic [7:0] matrix_q [0:6];
  logic [7:0] strobe_q;
  logic [7:0] dout_q, dout_d;
  logic       toggle_q;

  logic       key_event;
  logic       key_valid;
  logic [2:0] key_col;
  logic [2:0] key_row;
  logic [6:0] hit;
  logic [7:0] cols [0:8];
  logic [7:0] cols_or;

  assign key_event = ps2_key[10] != toggle_q;
  assign {key_valid, key_col, key_row} = hit;

  // {valid, col, row}; only the four arrow keys are recognised as extended codes
  always_comb begin
    hit = '0;
    if (ps2_key[8]) begin
      case (ps2_key[7:0])
        8'h75: hit = {1'b1, 3'd6, 3'd4};
        8'h72: hit = {1'b1, 3'd6, 3'd5};
        8'h6B: hit = {1'b1, 3'd6, 3'd6};
        8'h74: hit = {1'b1, 3'd6, 3'd7};
        default: hit = '0;
      endcase
    end else begin
      case (ps2_key[7:0])
        8'h45: hit = {1'b1, 3'd0, 3'd0};
        8'h16: hit = {1'b1, 3'd0, 3'd1};
        8'h1E: hit = {1'b1, 3'd0, 3'd2};
        8'h26: hit = {1'b1, 3'd0, 3'd3};
        8'h25: hit = {1'b1, 3'd0, 3'd4};
        8'h2E: hit = {1'b1, 3'd0, 3'd5};
        8'h36: hit = {1'b1, 3'd0, 3'd6};
        8'h3D: hit = {1'b1, 3'd0, 3'd7};
        8'h3E: hit = {1'b1, 3'd1, 3'd0};
        8'h46: hit = {1'b1, 3'd1, 3'd1};
        8'h52: hit = {1'b1, 3'd1, 3'd2};
        8'h4C: hit = {1'b1, 3'd1, 3'd3};
        8'h41: hit = {1'b1, 3'd1, 3'd4};
        8'h4E: hit = {1'b1, 3'd1, 3'd5};
        8'h49: hit = {1'b1, 3'd1, 3'd6};
        8'h4A: hit = {1'b1, 3'd1, 3'd7};
        8'h54: hit = {1'b1, 3'd2, 3'd0};
        8'h1C: hit = {1'b1, 3'd2, 3'd1};
        8'h32: hit = {1'b1, 3'd2, 3'd2};
        8'h21: hit = {1'b1, 3'd2, 3'd3};
        8'h23: hit = {1'b1, 3'd2, 3'd4};
        8'h24: hit = {1'b1, 3'd2, 3'd5};
        8'h2B: hit = {1'b1, 3'd2, 3'd6};
        8'h34: hit = {1'b1, 3'd2, 3'd7};
        8'h33: hit = {1'b1, 3'd3, 3'd0};
        8'h43: hit = {1'b1, 3'd3, 3'd1};
        8'h3B: hit = {1'b1, 3'd3, 3'd2};
        8'h42: hit = {1'b1, 3'd3, 3'd3};
        8'h4B: hit = {1'b1, 3'd3, 3'd4};
        8'h3A: hit = {1'b1, 3'd3, 3'd5};
        8'h31: hit = {1'b1, 3'd3, 3'd6};
        8'h44: hit = {1'b1, 3'd3, 3'd7};
        8'h4D: hit = {1'b1, 3'd4, 3'd0};
        8'h15: hit = {1'b1, 3'd4, 3'd1};
        8'h2D: hit = {1'b1, 3'd4, 3'd2};
        8'h1B: hit = {1'b1, 3'd4, 3'd3};
        8'h2C: hit = {1'b1, 3'd4, 3'd4};
        8'h3C: hit = {1'b1, 3'd4, 3'd5};
        8'h2A: hit = {1'b1, 3'd4, 3'd6};
        8'h1D: hit = {1'b1, 3'd4, 3'd7};
        8'h22: hit = {1'b1, 3'd5, 3'd0};
        8'h35: hit = {1'b1, 3'd5, 3'd1};
        8'h1A: hit = {1'b1, 3'd5, 3'd2};
        8'h5B: hit = {1'b1, 3'd5, 3'd3};
        8'h5D: hit = {1'b1, 3'd5, 3'd4};
        8'h55: hit = {1'b1, 3'd5, 3'd5};
        8'h0E: hit = {1'b1, 3'd5, 3'd6};
        8'h5A: hit = {1'b1, 3'd5, 3'd7};
        8'h29: hit = {1'b1, 3'd6, 3'd0};
        8'h12: hit = {1'b1, 3'd6, 3'd1};
        8'h59: hit = {1'b1, 3'd6, 3'd1};
        8'h14: hit = {1'b1, 3'd6, 3'd2};
        8'h76: hit = {1'b1, 3'd6, 3'd3};
        default: hit = '0;
      endcase
    end
  end

  // Joystick columns bypass the matrix registers and track the inputs live
  always_comb begin
    for (int unsigned i = 0; i < 7; i++) cols[i] = matrix_q[i];
    cols[7] = {2'b00, joy1};
    cols[8] = {2'b00, joy2};
    cols_or = '0;
    for (int unsigned i = 0; i < 9; i++) cols_or = cols_or | cols[i];
  end

  always_comb begin
    dout_d = '0;
    if (!iorq_n && wr_n) begin
      if (addr == KB_PORT) begin
        if (strobe_q == 8'h30)
          dout_d = cols_or;
        else if (strobe_q >= 8'd1 && strobe_q <= 8'd9)
          dout_d = cols[4'(strobe_q - 8'd1)];
      end else if (addr == JOY_PORT) begin
        dout_d = ~{joy2[3:0], joy1[3:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    toggle_q <= ps2_key[10];
    if (reset) begin
      for (int unsigned i = 0; i < 7; i++) matrix_q[i] <= '0;
      strobe_q <= '0;
      dout_q   <= '0;
    end else begin
      dout_q <= dout_d;
      if (!iorq_n && !wr_n && addr == KB_PORT) strobe_q <= din;
      if (key_event && key_valid) matrix_q[key_col][key_row] <= ps2_key[9];
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_rx78_keyboard.sv
// Directed self-checking bench for rx78_keyboard.
module tb_rx78_keyboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  addr;
  logic        iorq_n;
  logic        wr_n;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic [10:0] ps2_key;
  logic [5:0]  joy1;
  logic [5:0]  joy2;

  int n_cmp = 0;
  int n_err = 0;

  rx78_keyboard #(.KB_PORT(8'hF4), .JOY_PORT(8'hF0)) dut (
    .clk(clk), .reset(reset), .addr(addr), .iorq_n(iorq_n), .wr_n(wr_n),
    .din(din), .dout(dout), .ps2_key(ps2_key), .joy1(joy1), .joy2(joy2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic kbd(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    tick();
  endtask

  task automatic out_port(input logic [7:0] a, input logic [7:0] d);
    iorq_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
    tick();
    iorq_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic in_port(input logic [7:0] a, input logic [7:0] exp, input string tag);
    iorq_n = 1'b0; wr_n = 1'b1; addr = a;
    tick();
    check(tag, dout, exp);
    iorq_n = 1'b1;
    tick();
    check({tag, "_idle"}, dout, 8'h00);
  endtask

  initial begin
    reset = 1'b1; addr = '0; iorq_n = 1'b1; wr_n = 1'b1; din = '0;
    ps2_key = '0; joy1 = '0; joy2 = '0;
    tick(); tick();
    reset = 1'b0;
    check("reset_dout", dout, 8'h00);

    // 1: strobe 0 reads zero
    in_port(8'hF4, 8'h00, "strobe0");

    // 2: A press/release on column 2
    kbd(1'b1, 1'b0, 8'h1C);
    out_port(8'hF4, 8'h03);
    in_port(8'hF4, 8'h02, "A_pressed");
    kbd(1'b0, 1'b0, 8'h1C);
    in_port(8'hF4, 8'h00, "A_released");

    // 3: digits and the OR-all strobe
    kbd(1'b1, 1'b0, 8'h16);
    kbd(1'b1, 1'b0, 8'h2E);
    out_port(8'hF4, 8'h01);
    in_port(8'hF4, 8'h22, "digits_1_5");
    kbd(1'b1, 1'b0, 8'h29);
    out_port(8'hF4, 8'h30);
    in_port(8'hF4, 8'h23, "or_all");
    kbd(1'b0, 1'b0, 8'h16);
    kbd(1'b0, 1'b0, 8'h2E);
    kbd(1'b0, 1'b0, 8'h29);
    in_port(8'hF4, 8'h00, "or_all_clear");

    // 4: extended decode
    kbd(1'b1, 1'b1, 8'h75);
    out_port(8'hF4, 8'h07);
    in_port(8'hF4, 8'h10, "ext_up");
    kbd(1'b1, 1'b0, 8'h75);
    in_port(8'hF4, 8'h10, "nonext_75");
    kbd(1'b1, 1'b1, 8'h12);
    in_port(8'hF4, 8'h10, "fake_shift");
    kbd(1'b0, 1'b1, 8'h75);
    kbd(1'b1, 1'b0, 8'h5A);
    out_port(8'hF4, 8'h06);
    in_port(8'hF4, 8'h80, "return");
    out_port(8'hF0, 8'h03);
    in_port(8'hF4, 8'h80, "other_port_write");
    in_port(8'hF2, 8'h00, "unaddressed");
    kbd(1'b0, 1'b0, 8'h5A);

    // 5: joysticks
    joy1 = 6'b010001;
    out_port(8'hF4, 8'h08);
    in_port(8'hF4, 8'h11, "joy1_col");
    in_port(8'hF0, 8'hFE, "joy_port");
    joy2 = 6'b100000;
    out_port(8'hF4, 8'h09);
    in_port(8'hF4, 8'h20, "joy2_col");
    joy2 = 6'b001010;
    in_port(8'hF0, 8'h5E, "joy_port2");
    out_port(8'hF4, 8'h0A);
    in_port(8'hF4, 8'h00, "strobe_0A");
    joy1 = '0; joy2 = '0;

    // Event coinciding with a read returns the pre-update column
    out_port(8'hF4, 8'h03);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
    iorq_n = 1'b0; wr_n = 1'b1; addr = 8'hF4;
    tick();
    check("coincide_old", dout, 8'h00);
    iorq_n = 1'b1;
    tick();
    in_port(8'hF4, 8'h02, "coincide_new");

    // 6: reset mid-press; a toggle during reset must not survive as an event
    kbd(1'b0, 1'b0, 8'h1C);
    kbd(1'b1, 1'b0, 8'h1C);
    reset = 1'b1;
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h32};
    tick();
    reset = 1'b0;
    check("reset_mid_dout", dout, 8'h00);
    tick();
    out_port(8'hF4, 8'h03);
    in_port(8'hF4, 8'h00, "after_reset");
    kbd(1'b1, 1'b0, 8'h32);
    in_port(8'hF4, 8'h04, "B_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
